// File: rtl/huffman_stream_encoder.sv
// Table-driven streaming Huffman encoder packing MSB-first into OUT_W-bit words.
// Define HUFF_ENC_BITCNT_EN to build the 32-bit accepted-code-bit counter.
module huffman_stream_encoder #(
  parameter  int SYM_W   = 4,
  parameter  int MAX_LEN = 15,
  parameter  int OUT_W   = 8,
  parameter  int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int MB_W    = $clog2(OUT_W + 1)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               tbl_we,
  input  logic [SYM_W-1:0]   tbl_addr,
  input  logic [LEN_W-1:0]   tbl_len,
  input  logic [MAX_LEN-1:0] tbl_code,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [SYM_W-1:0]   s_sym,
  input  logic               flush,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic               m_partial,
  output logic [MB_W-1:0]    m_bits,
  output logic               done,
  output logic               err,
  output logic [31:0]        bit_cnt
);

  localparam int ACC_W  = OUT_W + MAX_LEN - 1;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int NSYM   = 1 << SYM_W;

  localparam logic [FILL_W-1:0] OUT_WF = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] ACC_WF = FILL_W'(ACC_W);
  localparam logic [MB_W-1:0]   OUT_WB = MB_W'(OUT_W);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               err_q, err_d;

  logic [LEN_W-1:0]   tbl_len_q  [NSYM];
  logic [MAX_LEN-1:0] tbl_code_q [NSYM];

  logic [LEN_W-1:0]   len;
  logic [MAX_LEN-1:0] code;
  logic [FILL_W-1:0]  len_f;
  logic [FILL_W-1:0]  shamt;
  logic [ACC_W-1:0]   code_ext;
  logic               legal;
  logic               full;
  logic               push;
  logic               pop;

  // Lookups read the registered table, so a same-cycle write is not seen.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NSYM; i++) begin
        tbl_len_q[i]  <= '0;
        tbl_code_q[i] <= '0;
      end
    end else if (tbl_we) begin
      tbl_len_q[tbl_addr]  <= tbl_len;
      tbl_code_q[tbl_addr] <= tbl_code;
    end
  end

  assign len   = tbl_len_q[s_sym];
  assign code  = tbl_code_q[s_sym]
               & ~({MAX_LEN{1'b1}} << len);
  assign legal = (len != '0)
              && (32'(len) <= 32'(MAX_LEN));

  assign len_f    = FILL_W'(len);
  assign shamt    = ACC_WF - fill_q - len_f;
  assign code_ext = ACC_W'(code) << shamt;

  assign full = fill_q >= OUT_WF;

  always_comb begin
    m_valid = 1'b0;
    unique case (1'b1)
      (state_q == RUN):   m_valid = full;
      (state_q == FLUSH): m_valid = fill_q != '0;
      default:            m_valid = 1'b0;
    endcase
  end

  assign s_ready = nRST && (state_q == RUN) && !full;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  assign m_data    = acc_q[ACC_W-1 -: OUT_W];
  assign m_partial = m_valid && (state_q == FLUSH) && !full;
  assign m_bits    = !m_valid ? '0
                   : full     ? OUT_WB
                   :            MB_W'(fill_q);
  assign done      = state_q == DONE;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    err_d   = err_q;
    if (push) begin
      if (legal) begin
        acc_d  = acc_q | code_ext;
        fill_d = fill_q + len_f;
      end else begin
        err_d = 1'b1;
      end
    end
    // Bits below fill are always zero, so a plain shift also pads.
    if (pop) begin
      acc_d  = acc_q << OUT_W;
      fill_d = full ? fill_q - OUT_WF : '0;
    end
    unique case (1'b1)
      (state_q == RUN): begin
        if (flush) state_d = FLUSH;
      end
      (state_q == FLUSH): begin
        if (fill_q == '0) state_d = DONE;
      end
      (state_q == DONE): begin
        acc_d   = '0;
        fill_d  = '0;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      acc_q   <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

`ifdef HUFF_ENC_BITCNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push && legal) cnt_d = cnt_q + 32'(len);
    if (state_q == DONE) cnt_d = '0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bit_cnt = cnt_q;
`else
  assign bit_cnt = '0;
`endif

endmodule

// File: tb/tb_huffman_stream_encoder.sv
// Bench for huffman_stream_encoder: bit-queue reference model plus
// directed literal checks and a randomized phase.
module tb_huffman_stream_encoder;

  localparam int SYM_W   = 4;
  localparam int MAX_LEN = 15;
  localparam int OUT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int MB_W    = $clog2(OUT_W + 1);
  localparam int NSYM    = 1 << SYM_W;

  logic               CLK = 1'b0;
  logic               nRST = 1'b0;
  logic               tbl_we = 1'b0;
  logic [SYM_W-1:0]   tbl_addr = '0;
  logic [LEN_W-1:0]   tbl_len = '0;
  logic [MAX_LEN-1:0] tbl_code = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [SYM_W-1:0]   s_sym = '0;
  logic               flush = 1'b0;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic [OUT_W-1:0]   m_data;
  logic               m_partial;
  logic [MB_W-1:0]    m_bits;
  logic               done;
  logic               err;
  logic [31:0]        bit_cnt;

  always #5 CLK = ~CLK;

  huffman_stream_encoder #(
    .SYM_W(SYM_W), .MAX_LEN(MAX_LEN), .OUT_W(OUT_W)
  ) dut (
    .CLK(CLK), .nRST(nRST),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_len(tbl_len), .tbl_code(tbl_code),
    .s_valid(s_valid), .s_ready(s_ready), .s_sym(s_sym),
    .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_partial(m_partial), .m_bits(m_bits),
    .done(done), .err(err), .bit_cnt(bit_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: the stream is a queue of pending bits.
  typedef enum {M_RUN, M_FLUSH, M_DONE} mode_t;
  mode_t       mode = M_RUN;
  bit          q[$];
  int unsigned m_cnt = 0;
  bit          m_err = 1'b0;
  int          m_len [NSYM];
  int          m_code [NSYM];

  logic [OUT_W-1:0] mw[$];
  logic [OUT_W-1:0] dw[$];
  logic             dwp[$];
  int               dwb[$];

  logic             s_mv = 1'b0;
  logic             s_mp = 1'b0;
  logic [OUT_W-1:0] s_md = '0;
  logic [MB_W-1:0]  s_mb = '0;
  int               dut_done_n = 0;
  logic [31:0]      bc_at_done = '0;

  bit acc_s, pop_s;
  int sz0, ln, npop;

  function automatic logic exp_sready();
    return nRST && mode == M_RUN && q.size() < OUT_W;
  endfunction

  function automatic logic exp_mvalid();
    return (mode == M_RUN && q.size() >= OUT_W)
        || (mode == M_FLUSH && q.size() > 0);
  endfunction

  function automatic logic [OUT_W-1:0] exp_word();
    logic [OUT_W-1:0] w = '0;
    for (int i = 0; i < OUT_W; i++)
      if (i < q.size()) w[OUT_W-1-i] = q[i];
    return w;
  endfunction

  function automatic int exp_bits();
    if (!exp_mvalid()) return 0;
    return (q.size() >= OUT_W) ? OUT_W : q.size();
  endfunction

  function automatic logic [31:0] exp_bitcnt();
`ifdef HUFF_ENC_BITCNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mode = M_RUN;
      q.delete();
      m_cnt = 0;
      m_err = 1'b0;
      for (int i = 0; i < NSYM; i++) begin
        m_len[i]  = 0;
        m_code[i] = 0;
      end
    end else begin
      sz0   = q.size();
      acc_s = exp_sready() && s_valid;
      pop_s = exp_mvalid() && m_ready;
      if (s_mv && m_ready) begin
        dw.push_back(s_md);
        dwp.push_back(s_mp);
        dwb.push_back(int'(s_mb));
      end
      if (pop_s) begin
        mw.push_back(exp_word());
        npop = (sz0 >= OUT_W) ? OUT_W : sz0;
        for (int i = 0; i < npop; i++) void'(q.pop_front());
      end
      if (acc_s) begin
        ln = m_len[s_sym];
        if (ln == 0 || ln > MAX_LEN) begin
          m_err = 1'b1;
        end else begin
          for (int b = ln - 1; b >= 0; b--)
            q.push_back(bit'((m_code[s_sym] >> b) & 1));
          m_cnt += ln;
        end
      end
      case (mode)
        M_RUN:   if (flush) mode = M_FLUSH;
        M_FLUSH: if (sz0 == 0) mode = M_DONE;
        default: begin
          q.delete();
          m_cnt = 0;
          mode = M_RUN;
        end
      endcase
      if (tbl_we) begin
        m_len[tbl_addr]  = int'(tbl_len);
        m_code[tbl_addr] = int'(tbl_code);
      end
    end
  end

  always @(negedge CLK) begin
    s_mv = m_valid;
    s_md = m_data;
    s_mp = m_partial;
    s_mb = m_bits;
    chk("s_ready", s_ready, exp_sready());
    chk("m_valid", m_valid, exp_mvalid());
    chk("m_data", m_data, exp_word());
    chk("m_partial", m_partial,
        exp_mvalid() && mode == M_FLUSH && q.size() < OUT_W);
    chk("m_bits", m_bits, exp_bits());
    chk("done", done, mode == M_DONE);
    chk("err", err, m_err);
    chk("bit_cnt", bit_cnt, exp_bitcnt());
    if (done) begin
      dut_done_n++;
      bc_at_done = bit_cnt;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int a, input int l, input int c);
    tbl_we   = 1'b1;
    tbl_addr = SYM_W'(a);
    tbl_len  = LEN_W'(l);
    tbl_code = MAX_LEN'(c);
    step();
    tbl_we = 1'b0;
  endtask

  task automatic push(input int sym);
    logic got = 1'b0;
    s_valid = 1'b1;
    s_sym   = SYM_W'(sym);
    for (int i = 0; i < 200 && !got; i++) begin
      got = s_ready;
      step();
    end
    s_valid = 1'b0;
    chk("push_accept", got, 1);
  endtask

  task automatic finish_stream();
    int n0 = dut_done_n;
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 300 && dut_done_n == n0; i++) step();
    repeat (3) step();
    chk("done_once", dut_done_n - n0, 1);
  endtask

  task automatic chk_word(input int idx, input logic [7:0] d,
                          input logic p, input int b);
    if (dw.size() > idx && mw.size() > idx) begin
      chk("word_data", dw[idx], d);
      chk("word_part", dwp[idx], p);
      chk("word_bits", dwb[idx], b);
      chk("model_word", mw[idx], d);
    end else begin
      chk("word_count", dw.size(), idx + 1);
    end
  endtask

  task automatic clr_words();
    dw.delete();
    dwp.delete();
    dwb.delete();
    mw.delete();
  endtask

  initial begin
    repeat (3) step();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    nRST = 1'b1;
    #1;
    chk("run_s_ready", s_ready, 1);
    step();

    // 4-bit codes: 0x1 then 0x2 form one word 0x12
    for (int k = 0; k < NSYM; k++) wr(k, 4, k);
    clr_words();
    m_ready = 1'b0;
    push(1);
    push(2);
    chk("t1_m_valid", m_valid, 1);
    chk("t1_m_data", m_data, 8'h12);
    chk("t1_m_bits", m_bits, 8);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk_word(0, 8'h12, 1'b0, 8);

    // Variable lengths 3,2,1,3 -> 0xF3 and a 1-bit tail
    wr(0, 1, 0);
    wr(1, 2, 2);
    wr(2, 3, 7);
    clr_words();
    m_ready = 1'b1;
    push(2);
    push(1);
    push(0);
    push(2);
    finish_stream();
    chk_word(0, 8'hF3, 1'b0, 8);
    chk_word(1, 8'h80, 1'b1, 1);
`ifdef HUFF_ENC_BITCNT_EN
    chk("t2_bit_cnt", bc_at_done, 9);
`else
    chk("t2_bit_cnt", bc_at_done, 0);
`endif

    // Backpressure: output held while m_ready is low
    wr(3, 4, 3);
    wr(4, 4, 4);
    wr(5, 4, 5);
    clr_words();
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_sym = 4'd3;
    step();
    s_sym = 4'd4;
    step();
    s_sym = 4'd5;
    for (int i = 0; i < 5; i++) begin
      chk("t3_s_ready", s_ready, 0);
      chk("t3_m_data", m_data, 8'h34);
      step();
    end
    m_ready = 1'b1;
    step();
    push(5);
    finish_stream();
    chk_word(0, 8'h34, 1'b0, 8);
    chk_word(1, 8'h50, 1'b1, 4);

    // Zero-length entry sets err and is dropped
    wr(6, 0, 0);
    clr_words();
    push(6);
    chk("t4_err", err, 1);
    chk("t4_m_valid", m_valid, 0);
    step();
    chk("t4_err_hold", err, 1);
    chk("t4_no_word", dw.size(), 0);

    // Flush with empty accumulator
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t5_done_n1", done, 0);
    chk("t5_mv_n1", m_valid, 0);
    step();
    chk("t5_done_n2", done, 1);
    chk("t5_mv_n2", m_valid, 0);
    step();
    chk("t5_done_n3", done, 0);

    // Mid-stream reset with 5 bits pending
    wr(0, 5, 5'b10101);
    m_ready = 1'b0;
    push(0);
    chk("t6_m_data", m_data, 8'hA8);
    nRST = 1'b0;
    #1;
    chk("t6_m_data_rst", m_data, 0);
    chk("t6_err_rst", err, 0);
    chk("t6_done_rst", done, 0);
    chk("t6_bits_rst", m_bits, 0);
    step();
    nRST = 1'b1;
    step();
    push(0);
    chk("t6_err_tbl", err, 1);
    chk("t6_mv_tbl", m_valid, 0);

    // Randomized traffic against the model
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    step();
    for (int k = 0; k < NSYM; k++)
      wr(k, $urandom_range(1, MAX_LEN), int'($urandom));
    for (int i = 0; i < 4000; i++) begin
      s_valid  = 1'($urandom_range(0, 1));
      s_sym    = SYM_W'($urandom);
      m_ready  = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 40) == 0);
      tbl_we   = ($urandom_range(0, 20) == 0);
      tbl_addr = SYM_W'($urandom);
      tbl_len  = ($urandom_range(0, 9) == 0) ? '0
               : LEN_W'($urandom_range(1, MAX_LEN));
      tbl_code = MAX_LEN'($urandom);
      step();
    end
    s_valid = 1'b0;
    flush   = 1'b0;
    tbl_we  = 1'b0;
    m_ready = 1'b1;
    finish_stream();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
